// File: rtl/ldtu_pkg.sv
// Shared constants and FSM state type for the LDTU serializer gearbox.
package ldtu_pkg;

    localparam int unsigned LDTU_NBITS_32  = 32;
    localparam int unsigned LDTU_NBITS_8   = 8;
    localparam int unsigned LDTU_IDLE_CNT_W = 16;
    localparam int unsigned LDTU_ALIGN_CNT_W = 4;

    typedef enum logic {
        ALIGN = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/ldtu_ser_gearbox.sv
// 32-bit word to 8-bit lane gearbox: MSB byte first, idle insertion, post-reset alignment.
// Optional idle-word counter enabled by macro LDTU_SER_IDLE_CNT_EN.
module ldtu_ser_gearbox
    import ldtu_pkg::*;
#(
    parameter int unsigned Nbits_32 = LDTU_NBITS_32,
    parameter int unsigned Nbits_8  = LDTU_NBITS_8,
    parameter int unsigned N_ALIGN  = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [Nbits_32-1:0] DATA32_in,
    input  logic                word_valid,
    input  logic [Nbits_32-1:0] idle_pattern,
    output logic                handshake,
    output logic [Nbits_8-1:0]  ser_out,
    output logic                ser_frame,
    output logic                idle_flag
`ifdef LDTU_SER_IDLE_CNT_EN
    ,
    output logic [LDTU_IDLE_CNT_W-1:0] idle_cnt
`endif
);

    localparam int unsigned LANES  = Nbits_32 / Nbits_8;
    localparam int unsigned IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned ACNT_W = LDTU_ALIGN_CNT_W;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(LANES - 1);
    localparam logic [ACNT_W-1:0] ALIGN_LAST = ACNT_W'(N_ALIGN - 1);

    state_t              state;
    state_t              state_nxt;
    logic [Nbits_32-1:0] sreg;
    logic [IDX_W-1:0]    byte_idx;
    logic [ACNT_W-1:0]   align_cnt;
    logic                load_cyc;
    logic                take_data;

    assign load_cyc  = (byte_idx == LAST_IDX);
    assign ser_out   = sreg[Nbits_32-1 -: Nbits_8];
    assign ser_frame = (byte_idx == '0);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ALIGN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: ALIGN leaves on the load that completes the last idle word
    always_comb begin
        state_nxt = state;
        case (state)
            ALIGN:   if (load_cyc && (align_cnt == ALIGN_LAST)) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = ALIGN;
        endcase
    end

    // Outputs: data is only taken in a RUN load cycle, never while reset is applied
    always_comb begin
        take_data = 1'b0;
        handshake = 1'b0;
        if (!RST && (state == RUN) && load_cyc && word_valid) begin
            take_data = 1'b1;
            handshake = 1'b1;
        end
    end

    // Shift register, byte index and alignment counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            sreg      <= '0;
            byte_idx  <= LAST_IDX;
            align_cnt <= '0;
            idle_flag <= 1'b1;
        end else if (load_cyc) begin
            byte_idx  <= '0;
            sreg      <= take_data ? DATA32_in : idle_pattern;
            idle_flag <= ~take_data;
            if (state == ALIGN) begin
                align_cnt <= align_cnt + ACNT_W'(1);
            end
        end else begin
            byte_idx <= byte_idx + IDX_W'(1);
            sreg     <= {sreg[Nbits_32-Nbits_8-1:0], {Nbits_8{1'b0}}};
        end
    end

`ifdef LDTU_SER_IDLE_CNT_EN
    // Saturating count of idle words inserted while running
    always_ff @(posedge CLK) begin
        if (RST) begin
            idle_cnt <= '0;
        end else if (load_cyc && (state == RUN) && !take_data && (idle_cnt != '1)) begin
            idle_cnt <= idle_cnt + LDTU_IDLE_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ldtu_ser_gearbox.sv
// Randomized bench for ldtu_ser_gearbox against a word-stream reference model.
module tb_ldtu_ser_gearbox;

    localparam int unsigned N_ALIGN = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] DATA32_in = '0;
    logic        word_valid = 1'b0;
    logic [31:0] idle_pattern = 32'h5A5A5A5A;
    logic        handshake;
    logic [7:0]  ser_out;
    logic        ser_frame;
    logic        idle_flag;
`ifdef LDTU_SER_IDLE_CNT_EN
    logic [15:0] idle_cnt;
`endif

    ldtu_ser_gearbox #(
        .Nbits_32 (32),
        .Nbits_8  (8),
        .N_ALIGN  (N_ALIGN)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .DATA32_in    (DATA32_in),
        .word_valid   (word_valid),
        .idle_pattern (idle_pattern),
        .handshake    (handshake),
        .ser_out      (ser_out),
        .ser_frame    (ser_frame),
        .idle_flag    (idle_flag)
`ifdef LDTU_SER_IDLE_CNT_EN
        ,
        .idle_cnt     (idle_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: cycles since reset release, and the word currently on the lane
    bit          m_live = 1'b0;
    int          m_t    = 0;
    logic [31:0] m_word = '0;
    bit          m_idle = 1'b1;
    int          m_icnt = 0;
    int          hs_at  = -1;
    logic [31:0] idle_pat = 32'h5A5A5A5A;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0d)", tag, got, exp, m_t);
        end
    endtask

    // One clock cycle: drive, compare at the falling edge, then advance the model
    task automatic step(input logic r, input logic v, input logic [31:0] d);
        bit   exp_hs;
        int   b;
        logic [7:0] exp_byte;
        @(posedge CLK);
        #1;
        RST          = r;
        word_valid   = v;
        DATA32_in    = d;
        idle_pattern = idle_pat;
        @(negedge CLK);

        exp_hs = !r && m_live && (m_t % 4 == 0) && (m_t / 4 >= int'(N_ALIGN)) && v;
        check("handshake", 32'(handshake), 32'(exp_hs));
        if (m_live) begin
            if (m_t == 0) begin
                check("ser_out_rst", 32'(ser_out), 32'h0);
                check("frame_rst", 32'(ser_frame), 32'h0);
                check("idle_flag_rst", 32'(idle_flag), 32'h1);
            end else begin
                b = (m_t - 1) % 4;
                exp_byte = 8'(m_word >> (8 * (3 - b)));
                check("ser_out", 32'(ser_out), 32'(exp_byte));
                check("ser_frame", 32'(ser_frame), 32'(b == 0));
                check("idle_flag", 32'(idle_flag), 32'(m_idle));
            end
`ifdef LDTU_SER_IDLE_CNT_EN
            check("idle_cnt", 32'(idle_cnt), 32'(m_icnt));
`endif
        end
        if (handshake === 1'b1 && hs_at < 0) hs_at = m_t;

        if (r) begin
            m_live = 1'b1;
            m_t    = 0;
            m_word = '0;
            m_idle = 1'b1;
            m_icnt = 0;
            hs_at  = -1;
        end else if (m_live) begin
            if (m_t % 4 == 0) begin
                if (exp_hs) begin
                    m_word = d;
                    m_idle = 1'b0;
                end else begin
                    m_word = idle_pat;
                    m_idle = 1'b1;
                    if (m_t / 4 >= int'(N_ALIGN) && m_icnt < 65535) m_icnt++;
                end
            end
            m_t++;
        end
    endtask

    task automatic goto_run_load();
        while (!(m_live && (m_t % 4 == 0) && (m_t / 4 >= int'(N_ALIGN))))
            step(1'b0, 1'b0, $urandom);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, $urandom);
    endtask

    logic [7:0] exp_seq [4];
    logic [7:0] seq_got;
    int         n_rst;

    initial begin
        exp_seq[0] = 8'hA1;
        exp_seq[1] = 8'hB2;
        exp_seq[2] = 8'hC3;
        exp_seq[3] = 8'hD4;

        // Alignment: word_valid held high from release, first handshake after 16 idle bytes
        idle_pat = 32'h5A5A5A5A;
        step(1'b1, 1'b1, 32'h0);
        step(1'b1, 1'b1, 32'h0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 32'hC0DE0000 + 32'(i));
        check("first_hs_cycle", 32'(hs_at), 32'd16);

        // Known word serialized MSB first; next handshake four cycles later
        goto_run_load();
        step(1'b0, 1'b1, 32'hA1B2C3D4);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 32'hDEADBEEF);
            seq_got = ser_out;
            check("a1b2c3d4_byte", 32'(seq_got), 32'(exp_seq[i]));
            if (i == 0) check("frame_on_a1", 32'(ser_frame), 32'h1);
            if (i == 3) check("hs_4_later", 32'(handshake), 32'h1);
        end

        // Idle insertion in RUN
        goto_run_load();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, $urandom);

        // word_valid only while byte_idx==1 must never be taken
        goto_run_load();
        for (int i = 0; i < 16; i++) step(1'b0, 1'(m_t % 4 == 2), $urandom);

        // Data word equal to idle_pattern still flagged as data
        goto_run_load();
        step(1'b0, 1'b1, idle_pat);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, $urandom);

        // Reset at byte_idx==2 of a consumed word: abort, realign, no replay
        goto_run_load();
        step(1'b0, 1'b1, 32'h11223344);
        step(1'b0, 1'b0, $urandom);
        step(1'b0, 1'b0, $urandom);
        step(1'b1, 1'b0, $urandom);
        step(1'b0, 1'b0, $urandom);
        check("abort_ser_out", 32'(ser_out), 32'h0);
        for (int i = 0; i < 28; i++) step(1'b0, 1'b0, $urandom);

        // Randomized traffic with occasional resets and idle pattern changes
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                idle_pat = $urandom;
                n_rst = int'($urandom_range(1, 3));
                do_reset(n_rst);
            end else begin
                step(1'b0, 1'($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 7) == 0) ? idle_pat : $urandom);
            end
        end

`ifdef LDTU_SER_IDLE_CNT_EN
        // Idle counter saturation
        do_reset(2);
        goto_run_load();
        for (int i = 0; i < 65540 * 4; i++) step(1'b0, 1'b0, $urandom);
        check("idle_cnt_sat", 32'(idle_cnt), 32'h0000FFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
